// File: rtl/creek_run_ctrl.sv
// Host-side run controller for the creek vector core: Avalon-MM control registers,
// run/wait/resume sequencing, gated instruction-memory loading, cycle counter, PC breakpoint.
module creek_run_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [9:0]  instr_address,
    output logic [15:0] instr_writedata,
    output logic        instr_write,
    output logic        pause_n,
    output logic        resume,
    input  logic        waiting,
    input  logic        local_init_done,
    input  logic [9:0]  pc
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInit = 3'd1,
        StRun  = 3'd2,
        StWait = 3'd3,
        StAck  = 3'd4
    } state_e;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrStatus = 3'd1;
    localparam logic [2:0] AddrInstr  = 3'd2;
    localparam logic [2:0] AddrCycles = 3'd3;
    localparam logic [2:0] AddrBreak  = 3'd4;
    localparam logic [2:0] AddrLastPc = 3'd5;

    state_e      state_q, state_d;
    logic        resume_q, resume_d;
    logic        instr_write_q, instr_write_d;
    logic [9:0]  instr_addr_q, instr_addr_d;
    logic [15:0] instr_data_q, instr_data_d;
    logic [31:0] cycles_q, cycles_d;
    logic [10:0] break_q, break_d;
    logic [9:0]  last_pc_q, last_pc_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic ctrl_wr, instr_wr, break_wr;
    logic cmd_start, cmd_stop, cmd_resume;
    logic running, bp_hit, start_ok;
    logic [31:0] rdata_mux;

    assign ctrl_wr  = avs_write && (avs_address == AddrCtrl);
    assign instr_wr = avs_write && (avs_address == AddrInstr);
    assign break_wr = avs_write && (avs_address == AddrBreak);

    // Only the highest-priority command bit of a CTRL write is considered.
    assign cmd_stop   = ctrl_wr && avs_writedata[1];
    assign cmd_resume = ctrl_wr && avs_writedata[2] && !avs_writedata[1];
    assign cmd_start  = ctrl_wr && avs_writedata[0] && !avs_writedata[1] && !avs_writedata[2];

    assign running = (state_q == StRun) || (state_q == StWait) || (state_q == StAck);
    assign bp_hit  = break_q[10] && (pc == break_q[9:0]);

    always_comb begin
        state_d  = state_q;
        resume_d = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    start_ok = 1'b1;
                    state_d  = local_init_done ? StRun : StInit;
                end
            end
            StInit: begin
                if (cmd_stop) begin
                    state_d = StIdle;
                end else if (local_init_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cmd_stop || bp_hit) begin
                    state_d = StIdle;
                end else if (waiting) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cmd_stop) begin
                    state_d = StIdle;
                end else if (cmd_resume) begin
                    state_d  = StAck;
                    resume_d = 1'b1;
                end
            end
            StAck: begin
                if (cmd_stop) begin
                    state_d = StIdle;
                end else if (!waiting) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_write_d = instr_wr && (state_q == StIdle);
        instr_addr_d  = instr_addr_q;
        instr_data_d  = instr_data_q;
        if (instr_write_d) begin
            instr_addr_d = avs_writedata[25:16];
            instr_data_d = avs_writedata[15:0];
        end

        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end else if (instr_wr && (state_q != StIdle)) begin
            err_d = 1'b1;
        end

        cycles_d = cycles_q;
        if (start_ok) begin
            cycles_d = 32'd0;
        end else if (pause_n && !waiting && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end

        break_d = break_wr ? avs_writedata[10:0] : break_q;

        last_pc_d = last_pc_q;
        if (running && (state_d == StIdle)) begin
            last_pc_d = pc;
        end
    end

    always_comb begin
        rdata_mux = 32'd0;
        case (avs_address)
            AddrStatus: rdata_mux = {26'd0, err_q, local_init_done, waiting, state_q};
            AddrCycles: rdata_mux = cycles_q;
            AddrBreak:  rdata_mux = {21'd0, break_q};
            AddrLastPc: rdata_mux = {22'd0, last_pc_q};
            default:    rdata_mux = 32'd0;
        endcase
        rdata_d = avs_read ? rdata_mux : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            resume_q      <= 1'b0;
            instr_write_q <= 1'b0;
            instr_addr_q  <= 10'd0;
            instr_data_q  <= 16'd0;
            cycles_q      <= 32'd0;
            break_q       <= 11'd0;
            last_pc_q     <= 10'd0;
            err_q         <= 1'b0;
            rdata_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            instr_write_q <= instr_write_d;
            instr_addr_q  <= instr_addr_d;
            instr_data_q  <= instr_data_d;
            cycles_q      <= cycles_d;
            break_q       <= break_d;
            last_pc_q     <= last_pc_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
        end
    end

    // Decoded from the registered state so an async reset drops it immediately.
    assign pause_n         = running;
    assign resume          = resume_q;
    assign instr_write     = instr_write_q;
    assign instr_address   = instr_addr_q;
    assign instr_writedata = instr_data_q;
    assign avs_readdata    = rdata_q;

endmodule

// File: doc/creek_run_ctrl.md
# creek_run_ctrl

Host-side run controller for the creek vector core. Sits between the Nios Avalon-MM fabric and the core's control pins. Sequences the core through load, run, wait/resume and stop. It owns the instruction-memory write port, which is gated so host writes land only while the core is parked. It also keeps a run-cycle counter and a single PC breakpoint.

## Interface
- No parameters. Widths are fixed: PC/instruction address 10 bits, instruction 16 bits, bus data 32 bits.
- clk  in  1  system clock (50 MHz domain shared with core and instr_mem)
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  3  word address of control register
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid exactly 1 cycle after avs_read (fixed read latency 1, no waitrequest)
- instr_address  out  10  instruction memory write address
- instr_writedata  out  16  instruction memory write data
- instr_write  out  1  instruction memory write enable
- pause_n  out  1  core run enable (0 = core frozen)
- resume  out  1  one-cycle pulse that releases a waiting core
- waiting  in  1  core is blocked awaiting resume
- local_init_done  in  1  DDR3 controller calibration complete
- pc  in  10  core instruction read address

## Operation
Registers, by word address:
- 0 CTRL (W): bit0 START, bit1 STOP, bit2 RESUME. Bits are write-1 commands and self-clear. If several bits are set in one write, STOP takes priority over RESUME, which takes priority over START. Reads return 0.
- 1 STATUS (R): [2:0] state code, [3] waiting, [4] local_init_done, [5] ERR (sticky).
- 2 INSTR (W): [25:16] address, [15:0] data.
- 3 CYCLES (R): run-cycle counter.
- 4 BREAK (R/W): [10] enable, [9:0] breakpoint PC. Reset value 0.
- 5 LAST_PC (R): pc captured on entry to IDLE from any running state. Reset value 0.
- Addresses 6–7 read 0; writes to them are ignored.

State machine (codes in parentheses):
- IDLE (0): pause_n = 0.
  - START with local_init_done = 1 -> RUN.
  - START with local_init_done = 0 -> INIT (1).
- INIT (1): pause_n = 0. local_init_done = 1 -> RUN. STOP -> IDLE.
- RUN (2): pause_n = 1.
  - STOP, or breakpoint hit (enable = 1 and pc == BREAK[9:0]) -> IDLE.
  - Otherwise waiting = 1 -> WAIT (3).
- WAIT (3): pause_n = 1. STOP -> IDLE. RESUME -> assert resume for one cycle and go to ACK (4).
- ACK (4): pause_n = 1, resume = 0. STOP -> IDLE. waiting = 0 -> RUN.
- Every entry into IDLE from RUN, WAIT or ACK latches LAST_PC <= pc in the same cycle as the transition.

Command validity:
- START is ignored outside IDLE.
- RESUME is ignored outside WAIT.
- STOP in IDLE is a no-op.

INSTR writes:
- Accepted only in IDLE. The next cycle drives instr_write = 1 for exactly one cycle, with the registered address and data.
- A write in any other state is dropped and sets ERR. ERR is cleared by START.
- Back-to-back INSTR writes on consecutive cycles each produce one write pulse. No write is lost.

CYCLES counter:
- Cleared to 0 by an accepted START.
- Increments by 1 on every cycle with pause_n = 1 and waiting = 0.
- Saturates at 0xFFFFFFFF; it does not wrap.
- Holds its value in IDLE.

## Timing
- Reset values:
  - state IDLE; pause_n 0, resume 0, instr_write 0.
  - instr_address 0, instr_writedata 0, avs_readdata 0.
  - CYCLES 0, BREAK 0, LAST_PC 0, ERR 0.
- Command latency: a CTRL write in cycle N updates the state register at edge N+1. pause_n and resume are decoded from the registered state, so they change in cycle N+1.
- Breakpoint: compared combinationally against pc in RUN. The hit is registered, so pause_n falls one cycle after pc matches, and LAST_PC equals the matching pc.
- Reset mid-operation: pause_n drops asynchronously and any pending resume or instr_write pulse is killed.
- A read of STATUS in the same cycle as a transition returns the pre-transition state.

## Test plan
- Reset, then read STATUS -> 0x00 (local_init_done low). Check pause_n = 0 and instr_write = 0.
- With local_init_done = 0, write CTRL = 1 -> STATUS state = 1 and pause_n stays 0. Raise local_init_done -> state = 2 and pause_n = 1 the next cycle.
- In IDLE, write INSTR 0x0005_ABCD -> one cycle later instr_write = 1, instr_address = 5, instr_writedata = 0xABCD. In RUN, the same write -> no pulse and STATUS[5] = 1.
- RUN for 100 cycles with waiting = 0, then STOP -> CYCLES = 100 ± command latency (exact value checked by the bench) and LAST_PC = pc at stop.
- Core raises waiting -> state 3. Write RESUME -> resume high for exactly 1 cycle, state 4. Drop waiting -> state 2. Check CYCLES does not count while waiting = 1.
- BREAK = 0x400 | 0x07F, sweep pc upward in RUN -> pause_n falls the cycle after pc = 0x07F and LAST_PC = 0x07F. A CTRL write of 0x7 in WAIT -> STOP wins, state 0, no resume pulse.
